// File: rtl/alu_pipe.sv
// alu_pipe: pipelined RV32I execution unit with valid/ready, mispredict flush and branch-tag free; `define ALU_MUL_EN adds MUL/MULH/MULHSU/MULHU
module alu_pipe #(
  parameter int XLEN = 32,
  parameter int TAG_W = 4,
  parameter int OP_W = 5,
  parameter int BTAG_W = 4,
  parameter int STAGES = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [XLEN-1:0]           operand_o,
  input  logic [XLEN-1:0]           operand_t,
  input  logic [OP_W-1:0]           op_code,
  input  logic [XLEN-1:0]           inst_addr,
  input  logic [TAG_W-1:0]          wrt_tag,
  input  logic [BTAG_W-1:0]         inst_btag,
  input  logic                      mis_taken,
  input  logic                      bfree_en,
  input  logic [$clog2(BTAG_W)-1:0] bfree_num,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [TAG_W-1:0]          out_tag,
  output logic [XLEN-1:0]           out_data,
  output logic [BTAG_W-1:0]         out_btag,
  output logic                      jump_en,
  output logic [XLEN-1:0]           jump_addr
);
  localparam int SH_W = $clog2(XLEN);
  localparam int L = STAGES - 1;
  localparam logic [OP_W-1:0] OP_ADD   = OP_W'(0);
  localparam logic [OP_W-1:0] OP_SUB   = OP_W'(1);
  localparam logic [OP_W-1:0] OP_AND   = OP_W'(2);
  localparam logic [OP_W-1:0] OP_OR    = OP_W'(3);
  localparam logic [OP_W-1:0] OP_XOR   = OP_W'(4);
  localparam logic [OP_W-1:0] OP_SLT   = OP_W'(5);
  localparam logic [OP_W-1:0] OP_SLTU  = OP_W'(6);
  localparam logic [OP_W-1:0] OP_SLL   = OP_W'(7);
  localparam logic [OP_W-1:0] OP_SRL   = OP_W'(8);
  localparam logic [OP_W-1:0] OP_SRA   = OP_W'(9);
  localparam logic [OP_W-1:0] OP_LUI   = OP_W'(10);
  localparam logic [OP_W-1:0] OP_AUIPC = OP_W'(11);
  localparam logic [OP_W-1:0] OP_JAL   = OP_W'(12);
  localparam logic [OP_W-1:0] OP_JALR  = OP_W'(13);
  if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
    $error("alu_pipe: STAGES must be in 1..4");
  end
  logic [XLEN-1:0]   sum, res, jmp;
  logic              jen;
  logic              advance;
  logic [BTAG_W-1:0] clr_mask;
  logic              valid_q [STAGES];
  logic              valid_d [STAGES];
  logic [TAG_W-1:0]  tag_q   [STAGES];
  logic [TAG_W-1:0]  tag_d   [STAGES];
  logic [XLEN-1:0]   data_q  [STAGES];
  logic [XLEN-1:0]   data_d  [STAGES];
  logic [BTAG_W-1:0] btag_q  [STAGES];
  logic [BTAG_W-1:0] btag_d  [STAGES];
  logic              jen_q   [STAGES];
  logic              jen_d   [STAGES];
  logic [XLEN-1:0]   jaddr_q [STAGES];
  logic [XLEN-1:0]   jaddr_d [STAGES];
`ifdef ALU_MUL_EN
  localparam logic [OP_W-1:0] OP_MUL    = OP_W'(14);
  localparam logic [OP_W-1:0] OP_MULH   = OP_W'(15);
  localparam logic [OP_W-1:0] OP_MULHSU = OP_W'(16);
  localparam logic [OP_W-1:0] OP_MULHU  = OP_W'(17);
  if (STAGES < 2) begin : g_bad_mul
    $error("alu_pipe: ALU_MUL_EN needs STAGES >= 2");
  end
  logic [2*XLEN-1:0] p_ss, p_su, p_uu;
  // Double-width products; signedness comes purely from how each operand is extended
  always_comb begin
    p_ss = {{XLEN{operand_o[XLEN-1]}}, operand_o} * {{XLEN{operand_t[XLEN-1]}}, operand_t};
    p_su = {{XLEN{operand_o[XLEN-1]}}, operand_o} * {{XLEN{1'b0}}, operand_t};
    p_uu = {{XLEN{1'b0}}, operand_o} * {{XLEN{1'b0}}, operand_t};
  end
`endif
  // Stage-0 execute: result, redirect target and jump flag straight from the issue inputs
  always_comb begin
    sum = operand_o + operand_t;
    res = '0;
    jmp = '0;
    jen = 1'b0;
    case (op_code)
      OP_ADD:   res = sum;
      OP_SUB:   res = operand_o - operand_t;
      OP_AND:   res = operand_o & operand_t;
      OP_OR:    res = operand_o | operand_t;
      OP_XOR:   res = operand_o ^ operand_t;
      OP_SLT:   res = ($signed(operand_o) < $signed(operand_t)) ? XLEN'(1) : '0;
      OP_SLTU:  res = (operand_o < operand_t) ? XLEN'(1) : '0;
      OP_SLL:   res = operand_o << operand_t[SH_W-1:0];
      OP_SRL:   res = operand_o >> operand_t[SH_W-1:0];
      OP_SRA:   res = $signed(operand_o) >>> operand_t[SH_W-1:0];
      OP_LUI:   res = operand_t;
      OP_AUIPC: res = sum;
      OP_JAL: begin
        res = operand_o + XLEN'(4);
        jmp = sum;
        jen = 1'b1;
      end
      OP_JALR: begin
        res = inst_addr + XLEN'(4);
        jmp = {sum[XLEN-1:1], 1'b0};
        jen = 1'b1;
      end
`ifdef ALU_MUL_EN
      OP_MUL:    res = p_ss[XLEN-1:0];
      OP_MULH:   res = p_ss[2*XLEN-1:XLEN];
      OP_MULHSU: res = p_su[2*XLEN-1:XLEN];
      OP_MULHU:  res = p_uu[2*XLEN-1:XLEN];
`endif
      default: ;
    endcase
  end
  assign advance  = ~valid_q[L] | out_ready;
  assign in_ready = advance & ~mis_taken;
  assign clr_mask = bfree_en ? ~(BTAG_W'(1) << bfree_num) : '1;
  // Next state: shift on advance, hold on stall, drop everything on flush, strip the freed branch bit in every slot
  always_comb begin
    valid_d[0] = mis_taken ? 1'b0 : advance ? in_valid : valid_q[0];
    tag_d[0]   = advance ? wrt_tag : tag_q[0];
    data_d[0]  = advance ? res : data_q[0];
    jen_d[0]   = advance ? jen : jen_q[0];
    jaddr_d[0] = advance ? jmp : jaddr_q[0];
    btag_d[0]  = (advance ? inst_btag : btag_q[0]) & clr_mask;
    for (int i = 1; i < STAGES; i++) begin
      valid_d[i] = mis_taken ? 1'b0 : advance ? valid_q[i-1] : valid_q[i];
      tag_d[i]   = advance ? tag_q[i-1] : tag_q[i];
      data_d[i]  = advance ? data_q[i-1] : data_q[i];
      jen_d[i]   = advance ? jen_q[i-1] : jen_q[i];
      jaddr_d[i] = advance ? jaddr_q[i-1] : jaddr_q[i];
      btag_d[i]  = (advance ? btag_q[i-1] : btag_q[i]) & clr_mask;
    end
  end
  // Stage registers; only valids reset because every payload output is gated by the last valid
  always_ff @(posedge clk) begin
    for (int i = 0; i < STAGES; i++) begin
      valid_q[i] <= rst ? valid_d[i] : 1'b0;
      tag_q[i]   <= tag_d[i];
      data_q[i]  <= data_d[i];
      jen_q[i]   <= jen_d[i];
      jaddr_q[i] <= jaddr_d[i];
      btag_q[i]  <= btag_d[i];
    end
  end
  assign out_valid = valid_q[L] & ~mis_taken;
  assign jump_en   = out_valid & jen_q[L];
  assign out_tag   = valid_q[L] ? tag_q[L] : '0;
  assign out_data  = valid_q[L] ? data_q[L] : '0;
  assign jump_addr = valid_q[L] ? jaddr_q[L] : '0;
  assign out_btag  = valid_q[L] ? (btag_q[L] & clr_mask) : '0;
endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed and random checks of alu_pipe against a queue-based reference model
module tb_alu_pipe;
  localparam int XLEN = 32, TAG_W = 4, OP_W = 5, BTAG_W = 4, STAGES = 2;
  localparam int BN_W = $clog2(BTAG_W);
  localparam logic [OP_W-1:0] ADD = 0, SUB = 1, AND_ = 2, OR_ = 3, XOR_ = 4, SLT = 5, SLTU = 6,
    SLL = 7, SRL = 8, SRA = 9, LUI = 10, AUIPC = 11, JAL = 12, JALR = 13,
    MUL = 14, MULH = 15, MULHSU = 16, MULHU = 17;
  logic clk = 0, rst = 0, in_valid = 0, mis_taken = 0, bfree_en = 0, out_ready = 1;
  logic [XLEN-1:0] operand_o = 0, operand_t = 0, inst_addr = 0;
  logic [OP_W-1:0] op_code = 0;
  logic [TAG_W-1:0] wrt_tag = 0;
  logic [BTAG_W-1:0] inst_btag = 0;
  logic [BN_W-1:0] bfree_num = 0;
  logic in_ready, out_valid, jump_en;
  logic [TAG_W-1:0] out_tag;
  logic [XLEN-1:0] out_data, jump_addr;
  logic [BTAG_W-1:0] out_btag;
  int checks = 0, errors = 0;
  typedef struct {
    logic [TAG_W-1:0]  tag;
    logic [XLEN-1:0]   data;
    logic [BTAG_W-1:0] btag;
    logic              jen;
    logic [XLEN-1:0]   jaddr;
    int                age;
  } ent_t;
  ent_t q[$];

  always #5 clk = ~clk;

  alu_pipe #(.XLEN(XLEN), .TAG_W(TAG_W), .OP_W(OP_W), .BTAG_W(BTAG_W), .STAGES(STAGES)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .operand_o(operand_o), .operand_t(operand_t), .op_code(op_code), .inst_addr(inst_addr),
    .wrt_tag(wrt_tag), .inst_btag(inst_btag), .mis_taken(mis_taken), .bfree_en(bfree_en),
    .bfree_num(bfree_num), .out_valid(out_valid), .out_ready(out_ready), .out_tag(out_tag),
    .out_data(out_data), .out_btag(out_btag), .jump_en(jump_en), .jump_addr(jump_addr));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic ent_t exec(input logic [OP_W-1:0] op, input logic [XLEN-1:0] a,
                                input logic [XLEN-1:0] b, input logic [XLEN-1:0] pc);
    ent_t e;
    longint sa, sb, sp;
    longint unsigned up;
    e = '{default:0};
    sa = $signed(a);
    sb = $signed(b);
    case (op)
      ADD:   e.data = a + b;
      SUB:   e.data = a - b;
      AND_:  e.data = a & b;
      OR_:   e.data = a | b;
      XOR_:  e.data = a ^ b;
      SLT:   e.data = (sa < sb) ? 32'd1 : 32'd0;
      SLTU:  e.data = (a < b) ? 32'd1 : 32'd0;
      SLL:   e.data = a << b[4:0];
      SRL:   e.data = a >> b[4:0];
      SRA:   e.data = 32'(sa >>> b[4:0]);
      LUI:   e.data = b;
      AUIPC: e.data = a + b;
      JAL:   begin e.data = a + 32'd4; e.jaddr = a + b; e.jen = 1'b1; end
      JALR:  begin e.data = pc + 32'd4; e.jaddr = (a + b) & ~32'd1; e.jen = 1'b1; end
`ifdef ALU_MUL_EN
      MUL:    begin sp = sa * sb; e.data = sp[31:0]; end
      MULH:   begin sp = sa * sb; e.data = sp[63:32]; end
      MULHSU: begin sp = sa * longint'({32'd0, b}); e.data = sp[63:32]; end
      MULHU:  begin up = {32'd0, a} * {32'd0, b}; e.data = up[63:32]; end
`endif
      default: e.data = 0;
    endcase
    return e;
  endfunction

  // one clock: compare outputs at negedge against the model head, then advance the model at the edge
  task automatic cyc();
    logic [BTAG_W-1:0] clr;
    bit last;
    ent_t h, n;
    @(negedge clk);
    clr = bfree_en ? ~(BTAG_W'(1) << bfree_num) : '1;
    last = q.size() > 0 && q[0].age == STAGES;
    h = '{default:0};
    if (last) h = q[0];
    chk("out_valid", out_valid, last && !mis_taken);
    chk("in_ready", in_ready, !(last && !out_ready) && !mis_taken);
    chk("jump_en", jump_en, last && h.jen && !mis_taken);
    chk("out_tag", out_tag, h.tag);
    chk("out_data", out_data, h.data);
    chk("jump_addr", jump_addr, h.jaddr);
    chk("out_btag", out_btag, h.btag & clr);
    @(posedge clk);
    if (!rst || mis_taken) q.delete();
    else begin
      if (!(last && !out_ready)) begin
        if (last) void'(q.pop_front());
        foreach (q[i]) q[i].age++;
        if (in_valid) begin
          n = exec(op_code, operand_o, operand_t, inst_addr);
          n.tag = wrt_tag;
          n.btag = inst_btag;
          n.age = 1;
          q.push_back(n);
        end
      end
      if (bfree_en) foreach (q[i]) q[i].btag[bfree_num] = 1'b0;
    end
    #1;
  endtask

  task automatic issue(input logic [OP_W-1:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                       input logic [XLEN-1:0] pc, input logic [TAG_W-1:0] t, input logic [BTAG_W-1:0] bt);
    in_valid = 1'b1;
    op_code = op;
    operand_o = a;
    operand_t = b;
    inst_addr = pc;
    wrt_tag = t;
    inst_btag = bt;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    cyc();
    rst = 1;
    chk("rst_valid", out_valid, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_data", out_data, 0);
    // back-to-back ADD then SRA
    issue(ADD, 5, 7, 32'h100, 3, 0);
    cyc();
    issue(SRA, 32'h8000_0000, 4, 32'h104, 4, 0);
    cyc();
    in_valid = 0;
    chk("add_valid", out_valid, 1);
    chk("add_data", out_data, 12);
    chk("add_tag", out_tag, 3);
    cyc();
    chk("sra_data", out_data, 32'hF800_0000);
    chk("sra_tag", out_tag, 4);
    cyc();
    // JALR redirect
    issue(JALR, 32'h1001, 4, 32'h200, 1, 0);
    cyc();
    in_valid = 0;
    cyc();
    chk("jalr_jen", jump_en, 1);
    chk("jalr_addr", jump_addr, 32'h1004);
    chk("jalr_data", out_data, 32'h204);
    cyc();
    // stall with a branch free in the middle
    out_ready = 0;
    issue(ADD, 1, 1, 0, 5, 4'b0110);
    cyc();
    issue(SUB, 9, 2, 0, 6, 4'b0110);
    cyc();
    issue(XOR_, 32'hFF, 32'h0F, 0, 7, 4'b0110);
    bfree_en = 1;
    bfree_num = 1;
    cyc();
    bfree_en = 0;
    cyc();
    cyc();
    chk("stall_ready", in_ready, 0);
    chk("stall_tag", out_tag, 5);
    chk("stall_data", out_data, 2);
    chk("stall_btag", out_btag, 4'b0100);
    out_ready = 1;
    cyc();
    in_valid = 0;
    chk("drain_tag6", out_tag, 6);
    chk("drain_btag6", out_btag, 4'b0100);
    cyc();
    chk("drain_tag7", out_tag, 7);
    chk("drain_data7", out_data, 32'hF0);
    chk("drain_btag7", out_btag, 4'b0110);
    cyc();
    // mispredict together with branch free
    issue(JAL, 32'h40, 8, 0, 8, 4'b0011);
    cyc();
    issue(ADD, 2, 3, 0, 9, 4'b0011);
    cyc();
    issue(OR_, 1, 2, 0, 10, 0);
    mis_taken = 1;
    bfree_en = 1;
    bfree_num = 0;
    #1;
    chk("flush_valid", out_valid, 0);
    chk("flush_jen", jump_en, 0);
    chk("flush_ready", in_ready, 0);
    cyc();
    mis_taken = 0;
    bfree_en = 0;
    issue(LUI, 0, 32'hABCD_E000, 0, 11, 0);
    #1;
    chk("post_flush_empty", out_valid, 0);
    cyc();
    in_valid = 0;
    chk("post_flush_empty2", out_valid, 0);
    cyc();
    chk("post_flush_valid", out_valid, 1);
    chk("post_flush_tag", out_tag, 11);
    chk("post_flush_data", out_data, 32'hABCD_E000);
    cyc();
    // reset with a full pipe
    issue(JAL, 32'h80, 16, 0, 12, 4'b1000);
    cyc();
    issue(JAL, 32'h90, 16, 0, 13, 4'b1000);
    cyc();
    in_valid = 0;
    rst = 0;
    cyc();
    rst = 1;
    chk("mrst_valid", out_valid, 0);
    chk("mrst_jen", jump_en, 0);
    chk("mrst_tag", out_tag, 0);
    chk("mrst_data", out_data, 0);
    chk("mrst_jaddr", jump_addr, 0);
    chk("mrst_btag", out_btag, 0);
    chk("mrst_ready", in_ready, 1);
    cyc();
    chk("mrst_gone", out_valid, 0);
`ifdef ALU_MUL_EN
    issue(MULHU, 32'hFFFF_FFFF, 2, 0, 2, 0);
    cyc();
    in_valid = 0;
    cyc();
    chk("mulhu", out_data, 1);
    cyc();
`endif
    // random traffic against the model
    for (int k = 0; k < 600; k++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      op_code = OP_W'($urandom_range(0, 20));
      operand_o = $urandom();
      operand_t = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom();
      inst_addr = $urandom();
      wrt_tag = TAG_W'($urandom());
      inst_btag = BTAG_W'($urandom());
      out_ready = ($urandom_range(0, 3) != 0);
      mis_taken = ($urandom_range(0, 29) == 0);
      bfree_en = ($urandom_range(0, 7) == 0);
      bfree_num = BN_W'($urandom());
      rst = ($urandom_range(0, 99) != 0);
      cyc();
    end
    in_valid = 0;
    out_ready = 1;
    mis_taken = 0;
    bfree_en = 0;
    rst = 1;
    repeat (STAGES + 2) cyc();
    chk("drained", 64'(q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
